// File: rtl/main_memory_ctrl.sv
// -----------------------------------------------------------------------------
// main_memory_ctrl
//   Main-memory stage that sits behind the cache controller. A line request is
//   sampled on MStrobe while idle, held off for WAIT_CYCLES wait states, then a
//   whole cache line moves as a word-serial burst (beat 0..N-1 ascending) to or
//   from the internal word array. A single-cycle MReady marks completion.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-low reset (array contents are kept)
//   MStrobe    : line request, only looked at while idle
//   MRW        : 0 = line read (fill), 1 = line write (writeback)
//   MAddr      : byte address; byte and word-in-line offset bits are dropped
//   MDataIn    : write data for the beat shown on MBeat
//   MDataOut   : read data of the current beat (zero when not valid)
//   MDataValid : MDataOut carries a read beat this cycle
//   MBeat      : word index of the current beat (0 outside bursts)
//   MBusy      : high whenever a request is in flight (not idle)
//   MReady     : one-cycle completion pulse
// -----------------------------------------------------------------------------
module main_memory_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int WAIT_CYCLES    = 4,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              MStrobe,
  input  logic                              MRW,
  input  logic [ADDR_W-1:0]                 MAddr,
  input  logic [DATA_W-1:0]                 MDataIn,
  output logic [DATA_W-1:0]                 MDataOut,
  output logic                              MDataValid,
  output logic [$clog2(WORDS_PER_LINE)-1:0] MBeat,
  output logic                              MBusy,
  output logic                              MReady
);

  localparam int BYTE_OFF = $clog2(DATA_W / 8);
  localparam int BEAT_W   = $clog2(WORDS_PER_LINE);
  localparam int WIDX_W   = $clog2(MEM_WORDS);
  localparam int LINE_W   = WIDX_W - BEAT_W;
  localparam int CNT_W    = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   mem_q [MEM_WORDS];

  // Only the line-index bits of MAddr matter; the byte offset, word-in-line
  // offset and bits above the array size are dropped on purpose.
  logic unused_addr_s;
  assign unused_addr_s = ^MAddr;

  // State register plus latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      rw_q    <= 1'b0;
      mdata_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      rw_q    <= rw_d;
      mdata_q <= mdata_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (MStrobe) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Counter is loaded with WAIT_CYCLES-1, so leaving on zero gives
        // exactly WAIT_CYCLES cycles here.
        if (cnt_q == '0) begin
          state_d = S_BURST;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_BURST: begin
        if (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BURST;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, wait counter and beat counter next values.
  always_comb begin
    cnt_d  = cnt_q;
    beat_d = '0;
    line_d = line_q;
    rw_d   = rw_q;
    case (state_q)
      S_IDLE: begin
        if (MStrobe) begin
          // Line index taken modulo the array size; the word-in-line bits are
          // implicitly zero because the beat counter supplies them.
          line_d = MAddr[BYTE_OFF + BEAT_W +: LINE_W];
          rw_d   = MRW;
          cnt_d  = CNT_W'(WAIT_CYCLES - 1);
        end else begin
          cnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      // Beat wraps to zero after the last beat, which is the DONE value.
      S_BURST: beat_d = beat_q + BEAT_W'(1);
      S_DONE:  cnt_d  = '0;
      default: cnt_d  = '0;
    endcase
  end

  // Output logic: outputs are decoded from the next state so they register
  // in the same cycle the state does.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_DONE);
    valid_d = (state_d == S_BURST) && !rw_d;
    if (valid_d) begin
      // Beat bits are concatenated below the line index, so the address can
      // never carry out of the line.
      mdata_d = mem_q[{line_d, beat_d}];
    end else begin
      mdata_d = '0;
    end
  end

  // Word array: write beats land at the end of each write-burst beat; the
  // reset qualifier stops an aborted burst from writing on the reset edge.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_BURST) && rw_q) begin
      mem_q[{line_q, beat_q}] <= MDataIn;
    end
  end

  assign MDataOut   = mdata_q;
  assign MDataValid = valid_q;
  assign MBeat      = beat_q;
  assign MBusy      = busy_q;
  assign MReady     = ready_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_main_memory_ctrl
//   Directed plus randomized bench for main_memory_ctrl with default
//   parameters. A plain word array models memory; expected timing follows the
//   request -> WAIT_CYCLES waits -> WORDS_PER_LINE beats -> one DONE cycle rule.
// -----------------------------------------------------------------------------
module tb_main_memory_ctrl;

  localparam int W = 4;   // wait states
  localparam int N = 4;   // beats per line

  logic        clk = 1'b0;
  logic        reset;
  logic        MStrobe;
  logic        MRW;
  logic [15:0] MAddr;
  logic [31:0] MDataIn;
  logic [31:0] MDataOut;
  logic        MDataValid;
  logic [1:0]  MBeat;
  logic        MBusy;
  logic        MReady;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem_m [1024];
  logic [31:0] wbuf  [4];
  int          written_q [$];

  main_memory_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .MStrobe    (MStrobe),
    .MRW        (MRW),
    .MAddr      (MAddr),
    .MDataIn    (MDataIn),
    .MDataOut   (MDataOut),
    .MDataValid (MDataValid),
    .MBeat      (MBeat),
    .MBusy      (MBusy),
    .MReady     (MReady)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // First word of the line addressed by a byte address, modulo the array.
  function automatic int line_base(input logic [15:0] a);
    int word;
    word = int'(a) / 4;
    return ((word / N) * N) % 1024;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(MBusy),      32'd0);
    chk({tag, "_ready"}, 32'(MReady),     32'd0);
    chk({tag, "_valid"}, 32'(MDataValid), 32'd0);
    chk({tag, "_beat"},  32'(MBeat),      32'd0);
  endtask

  // Issue one request and check every cycle up to and including DONE.
  // Called #1 after a rising edge with the DUT either idle or in DONE.
  task automatic run_txn(input logic rw, input logic [15:0] addr,
                         input bit from_done, input bit hold, output int rcyc);
    int  base;
    bit  in_burst;
    int  beat;
    base    = line_base(addr);
    MStrobe = 1'b1;
    MRW     = rw;
    MAddr   = addr;
    rcyc    = -1;
    if (from_done) begin
      @(posedge clk); #1;
      chk_idle("gap");
    end
    @(posedge clk); #1;            // request sampled on this edge
    for (int i = 0; i <= W + N; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      in_burst = (i >= W) && (i < W + N);
      beat     = in_burst ? (i - W) : 0;
      chk("busy",  32'(MBusy),      32'd1);
      chk("ready", 32'(MReady),     32'(i == W + N));
      chk("valid", 32'(MDataValid), 32'(in_burst && !rw));
      chk("beat",  32'(MBeat),      32'(beat));
      if (in_burst && !rw) begin
        chk("rdata", MDataOut, mem_m[base + beat]);
      end
      if (i == W + N) begin
        rcyc = cyc;
      end
      if (in_burst && rw) begin
        MDataIn = wbuf[beat];
      end else begin
        MDataIn = $urandom;
      end
      // Disturb the request inputs while busy; they must be ignored.
      if (i < W + N) begin
        MStrobe = hold ? 1'b1 : ((i == 1) ? 1'b1 : 1'($urandom_range(0, 1)));
        MAddr   = (i == 1) ? 16'h0100 : 16'($urandom);
        MRW     = 1'($urandom_range(0, 1));
      end else begin
        MStrobe = hold;
      end
    end
    if (rw) begin
      for (int b = 0; b < N; b++) begin
        mem_m[base + b] = wbuf[b];
      end
    end
  endtask

  initial begin
    int rc;
    int prev_rc;
    int line;
    int pick;
    logic [15:0] a;

    reset   = 1'b0;
    MStrobe = 1'b1;
    MRW     = 1'b0;
    MAddr   = 16'h0000;
    MDataIn = 32'h0;

    // Reset held two cycles with a pending strobe.
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst_data", MDataOut, 32'h0);
    MStrobe = 1'b0;
    reset   = 1'b1;
    @(posedge clk); #1;
    chk_idle("rst_rel");

    // Write line 0x0040 then read it back.
    for (int b = 0; b < N; b++) wbuf[b] = 32'hA0 + 32'(b);
    run_txn(1'b1, 16'h0040, 1'b0, 1'b0, rc);
    run_txn(1'b0, 16'h0040, 1'b1, 1'b0, rc);

    // Unaligned address reads the same line from beat 0.
    run_txn(1'b0, 16'h004C, 1'b1, 1'b0, rc);

    // Reset in beat 1 of a write: only beat 0 lands.
    MStrobe = 1'b1;
    MRW     = 1'b1;
    MAddr   = 16'h0040;
    for (int b = 0; b < N; b++) wbuf[b] = 32'hB0 + 32'(b);
    @(posedge clk); #1;
    chk_idle("ab_gap");
    @(posedge clk); #1;
    MStrobe = 1'b0;
    repeat (W) begin
      @(posedge clk); #1;
    end
    chk("ab_beat0", 32'(MBeat), 32'd0);
    MDataIn = wbuf[0];
    @(posedge clk); #1;
    chk("ab_beat1", 32'(MBeat), 32'd1);
    MDataIn = wbuf[1];
    reset   = 1'b0;
    @(posedge clk); #1;
    chk_idle("ab_rst");
    chk("ab_rst_data", MDataOut, 32'h0);
    reset = 1'b1;
    mem_m[16] = 32'hB0;
    run_txn(1'b0, 16'h0040, 1'b0, 1'b0, rc);

    // Line 0 gets known data so a wrap from the top line would show.
    for (int b = 0; b < N; b++) wbuf[b] = 32'hC0 + 32'(b);
    run_txn(1'b1, 16'h0000, 1'b1, 1'b0, rc);

    // Back-to-back with strobe held high at the top line (word 1020).
    prev_rc = -1;
    for (int t = 0; t < 6; t++) begin
      if ((t % 2) == 0) begin
        for (int b = 0; b < N; b++) wbuf[b] = $urandom;
      end
      run_txn(((t % 2) == 0) ? 1'b1 : 1'b0, 16'h0FF0, 1'b1, 1'b1, rc);
      if (prev_rc >= 0) begin
        chk("b2b_gap", 32'(rc - prev_rc), 32'd10);
      end
      prev_rc = rc;
    end
    MStrobe = 1'b0;
    run_txn(1'b0, 16'h0000, 1'b1, 1'b0, rc);

    // Random writes and reads, including address bits above the array.
    written_q.push_back(4);
    written_q.push_back(255);
    written_q.push_back(0);
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        pick = int'($urandom_range(0, written_q.size() - 1));
        line = written_q[pick];
        a    = 16'(($urandom_range(0, 15) << 12) | (line << 4) | $urandom_range(0, 15));
        run_txn(1'b0, a, 1'b1, 1'b0, rc);
      end else begin
        line = int'($urandom_range(0, 255));
        a    = 16'(($urandom_range(0, 15) << 12) | (line << 4) | $urandom_range(0, 15));
        for (int b = 0; b < N; b++) wbuf[b] = $urandom;
        run_txn(1'b1, a, 1'b1, 1'b0, rc);
        written_q.push_back(line);
      end
    end

    @(posedge clk); #1;
    chk_idle("end");
    repeat (3) begin
      @(posedge clk); #1;
      chk_idle("quiet");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
